// File: rtl/iob_pfsm_input_cond.sv
// Input conditioner for the PFSM: 2-flop synchroniser, per-bit debounce,
// edge pulses, a pending-event set with ready/valid accept, and sticky overflow flags.
module iob_pfsm_input_cond #(
    parameter int INPUT_W = 1,
    parameter int CNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cke_i,
    input  logic [INPUT_W-1:0] raw_i,
    input  logic [CNT_W-1:0]   limit_i,
    input  logic               evt_ready_i,
    input  logic               ovf_clr_i,
    output logic [INPUT_W-1:0] input_ports_o,
    output logic [INPUT_W-1:0] rise_o,
    output logic [INPUT_W-1:0] fall_o,
    output logic               evt_valid_o,
    output logic [INPUT_W-1:0] evt_rise_o,
    output logic [INPUT_W-1:0] evt_fall_o,
    output logic [INPUT_W-1:0] ovf_o
);

    logic [INPUT_W-1:0] s1;
    logic [INPUT_W-1:0] s2;
    logic [INPUT_W-1:0] stable;
    logic [INPUT_W-1:0] rise_q;
    logic [INPUT_W-1:0] fall_q;
    logic [INPUT_W-1:0] evt_rise;
    logic [INPUT_W-1:0] evt_fall;
    logic [INPUT_W-1:0] ovf;
    logic [CNT_W-1:0]   cnt     [INPUT_W];
    logic [CNT_W-1:0]   cnt_nxt [INPUT_W];

    logic [INPUT_W-1:0] commit;
    logic [INPUT_W-1:0] new_rise;
    logic [INPUT_W-1:0] new_fall;
    logic [INPUT_W-1:0] ovf_set;
    logic               accepted;

    // A bit commits once it has disagreed with stable for limit_i+1 samples;
    // >= lets a lowered limit end the count immediately, so cnt never wraps.
    always_comb begin
        commit = '0;
        for (int i = 0; i < INPUT_W; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != stable[i]) begin
                if (cnt[i] >= limit_i) begin
                    commit[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign new_rise = commit & s2;
    assign new_fall = commit & ~s2;
    assign accepted = evt_valid_o & evt_ready_i;
    assign ovf_set  = (new_rise & evt_rise & {INPUT_W{~accepted}})
                    | (new_fall & evt_fall & {INPUT_W{~accepted}});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            evt_rise <= '0;
            evt_fall <= '0;
            ovf      <= '0;
            for (int i = 0; i < INPUT_W; i++) begin
                cnt[i] <= '0;
            end
        end else if (cke_i) begin
            s1       <= raw_i;
            s2       <= s1;
            stable   <= stable ^ commit;
            rise_q   <= new_rise;
            fall_q   <= new_fall;
            // An accept and a new edge in the same cycle leave only the new edge pending.
            evt_rise <= (accepted ? '0 : evt_rise) | new_rise;
            evt_fall <= (accepted ? '0 : evt_fall) | new_fall;
            ovf      <= (ovf_clr_i ? '0 : ovf) | ovf_set;
            for (int i = 0; i < INPUT_W; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign input_ports_o = stable;
    assign rise_o        = rise_q;
    assign fall_o        = fall_q;
    assign evt_rise_o    = evt_rise;
    assign evt_fall_o    = evt_fall;
    assign evt_valid_o   = |(evt_rise | evt_fall);
    assign ovf_o         = ovf;

endmodule

// File: tb/tb_iob_pfsm_input_cond.sv
// Directed self-checking bench for iob_pfsm_input_cond with INPUT_W=2, CNT_W=8.
module tb_iob_pfsm_input_cond;

    logic       clk;
    logic       rst;
    logic       cke;
    logic [1:0] raw;
    logic [7:0] limit;
    logic       evt_ready;
    logic       ovf_clr;
    logic [1:0] input_ports;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       evt_valid;
    logic [1:0] evt_rise;
    logic [1:0] evt_fall;
    logic [1:0] ovf;

    int tests;
    int failed;

    iob_pfsm_input_cond #(.INPUT_W(2), .CNT_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cke_i        (cke),
        .raw_i        (raw),
        .limit_i      (limit),
        .evt_ready_i  (evt_ready),
        .ovf_clr_i    (ovf_clr),
        .input_ports_o(input_ports),
        .rise_o       (rise),
        .fall_o       (fall),
        .evt_valid_o  (evt_valid),
        .evt_rise_o   (evt_rise),
        .evt_fall_o   (evt_fall),
        .ovf_o        (ovf)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        raw = 2'b00;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic accept_all();
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        tests++; if (input_ports !== 2'b00) begin failed++; $display("[TB] FAIL reset_input_ports: got %b expected 00", input_ports); end
        tests++; if ({rise, fall} !== 4'b0000) begin failed++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {rise, fall}); end
        tests++; if (evt_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_evt_valid: got %b expected 0", evt_valid); end
        tests++; if ({evt_rise, evt_fall} !== 4'b0000) begin failed++; $display("[TB] FAIL reset_pending: got %b expected 0000", {evt_rise, evt_fall}); end
        tests++; if (ovf !== 2'b00) begin failed++; $display("[TB] FAIL reset_ovf: got %b expected 00", ovf); end
        rst = 1'b0;
    endtask

    task automatic test_rise_latency();
        raw = 2'b01;
        tick(5);
        tests++; if (input_ports !== 2'b00) begin failed++; $display("[TB] FAIL rise_early: got %b expected 00", input_ports); end
        tick(1);
        tests++; if (input_ports !== 2'b01) begin failed++; $display("[TB] FAIL rise_stable: got %b expected 01", input_ports); end
        tests++; if (rise !== 2'b01) begin failed++; $display("[TB] FAIL rise_pulse: got %b expected 01", rise); end
        tests++; if (evt_valid !== 1'b1 || evt_rise !== 2'b01) begin failed++; $display("[TB] FAIL rise_event: got valid=%b rise=%b expected valid=1 rise=01", evt_valid, evt_rise); end
        tick(1);
        tests++; if (rise !== 2'b00) begin failed++; $display("[TB] FAIL rise_one_cycle: got %b expected 00", rise); end
        tests++; if (evt_rise !== 2'b01) begin failed++; $display("[TB] FAIL rise_pending_hold: got %b expected 01", evt_rise); end
        accept_all();
        tests++; if (evt_valid !== 1'b0) begin failed++; $display("[TB] FAIL rise_accept: got %b expected 0", evt_valid); end
    endtask

    task automatic test_fall();
        raw = 2'b00;
        tick(6);
        tests++; if (input_ports !== 2'b00) begin failed++; $display("[TB] FAIL fall_stable: got %b expected 00", input_ports); end
        tests++; if (fall !== 2'b01 || rise !== 2'b00) begin failed++; $display("[TB] FAIL fall_pulse: got fall=%b rise=%b expected fall=01 rise=00", fall, rise); end
        tests++; if (evt_fall !== 2'b01) begin failed++; $display("[TB] FAIL fall_event: got %b expected 01", evt_fall); end
        accept_all();
        tests++; if (evt_valid !== 1'b0) begin failed++; $display("[TB] FAIL fall_accept: got %b expected 0", evt_valid); end
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        raw = 2'b01;
        tick(3);
        raw = 2'b00;
        repeat (12) begin
            tick(1);
            if (input_ports !== 2'b00 || rise !== 2'b00 || fall !== 2'b00 || evt_valid !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin failed++; $display("[TB] FAIL glitch_dropped: got activity=%b expected 0", seen); end
    endtask

    task automatic test_min_pulse();
        raw = 2'b01;
        tick(4);
        raw = 2'b00;
        tick(1);
        tests++; if (input_ports !== 2'b00) begin failed++; $display("[TB] FAIL min_pulse_early: got %b expected 00", input_ports); end
        tick(1);
        tests++; if (input_ports !== 2'b01 || rise !== 2'b01) begin failed++; $display("[TB] FAIL min_pulse_taken: got in=%b rise=%b expected in=01 rise=01", input_ports, rise); end
        tick(4);
        tests++; if (input_ports !== 2'b00 || fall !== 2'b01) begin failed++; $display("[TB] FAIL min_pulse_fall: got in=%b fall=%b expected in=00 fall=01", input_ports, fall); end
        accept_all();
    endtask

    task automatic test_overflow();
        raw = 2'b01;
        tick(6);
        tests++; if (evt_rise !== 2'b01) begin failed++; $display("[TB] FAIL ovf_first_rise: got %b expected 01", evt_rise); end
        raw = 2'b00;
        tick(6);
        tests++; if (evt_rise !== 2'b01 || evt_fall !== 2'b01) begin failed++; $display("[TB] FAIL ovf_both_edges: got rise=%b fall=%b expected 01 01", evt_rise, evt_fall); end
        tests++; if (ovf !== 2'b00) begin failed++; $display("[TB] FAIL ovf_not_yet: got %b expected 00", ovf); end
        raw = 2'b01;
        tick(6);
        tests++; if (ovf !== 2'b01) begin failed++; $display("[TB] FAIL ovf_set: got %b expected 01", ovf); end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        tests++; if (ovf !== 2'b00) begin failed++; $display("[TB] FAIL ovf_clear: got %b expected 00", ovf); end
        accept_all();
        tests++; if (evt_valid !== 1'b0) begin failed++; $display("[TB] FAIL ovf_accept: got %b expected 0", evt_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        raw = 2'b01;
        tick(6);
        raw = 2'b11;
        tick(5);
        tests++; if (evt_rise !== 2'b01) begin failed++; $display("[TB] FAIL b2b_before: got %b expected 01", evt_rise); end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        tests++; if (evt_rise !== 2'b10 || evt_valid !== 1'b1) begin failed++; $display("[TB] FAIL b2b_new_kept: got rise=%b valid=%b expected 10 1", evt_rise, evt_valid); end
        tests++; if (ovf !== 2'b00) begin failed++; $display("[TB] FAIL b2b_no_ovf: got %b expected 00", ovf); end
        accept_all();
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        raw = 2'b01;
        tick(4);
        rst = 1'b1;
        tick(1);
        tests++; if ({input_ports, rise, fall, evt_valid, evt_rise, evt_fall, ovf} !== 13'd0) begin
            failed++; $display("[TB] FAIL midreset_outputs: got %b expected all zero", {input_ports, rise, fall, evt_valid, evt_rise, evt_fall, ovf});
        end
        rst = 1'b0;
        tick(5);
        tests++; if (input_ports !== 2'b00) begin failed++; $display("[TB] FAIL midreset_early: got %b expected 00", input_ports); end
        tick(1);
        tests++; if (input_ports !== 2'b01 || rise !== 2'b01) begin failed++; $display("[TB] FAIL midreset_requalify: got in=%b rise=%b expected 01 01", input_ports, rise); end
        accept_all();
    endtask

    task automatic test_cke_stall();
        logic held;
        do_reset();
        raw = 2'b01;
        tick(3);
        cke = 1'b0;
        tick(10);
        tests++; if (input_ports !== 2'b00) begin failed++; $display("[TB] FAIL stall_frozen: got %b expected 00", input_ports); end
        cke = 1'b1;
        tick(2);
        tests++; if (input_ports !== 2'b00) begin failed++; $display("[TB] FAIL stall_early: got %b expected 00", input_ports); end
        tick(1);
        tests++; if (input_ports !== 2'b01 || rise !== 2'b01) begin failed++; $display("[TB] FAIL stall_delayed: got in=%b rise=%b expected 01 01", input_ports, rise); end
        cke = 1'b0;
        evt_ready = 1'b1;
        held = 1'b1;
        repeat (10) begin
            tick(1);
            if (rise !== 2'b01 || evt_valid !== 1'b1) held = 1'b0;
        end
        tests++; if (held !== 1'b1) begin failed++; $display("[TB] FAIL stall_pulse_held: got held=%b expected 1", held); end
        cke = 1'b1;
        evt_ready = 1'b0;
        tick(1);
        tests++; if (rise !== 2'b00 || evt_valid !== 1'b1) begin failed++; $display("[TB] FAIL stall_resume: got rise=%b valid=%b expected 00 1", rise, evt_valid); end
        accept_all();
    endtask

    task automatic test_limit();
        do_reset();
        limit = 8'd0;
        raw = 2'b01;
        tick(2);
        tests++; if (input_ports !== 2'b00) begin failed++; $display("[TB] FAIL limit0_early: got %b expected 00", input_ports); end
        tick(1);
        tests++; if (input_ports !== 2'b01) begin failed++; $display("[TB] FAIL limit0_latency: got %b expected 01", input_ports); end
        do_reset();
        limit = 8'd20;
        raw = 2'b01;
        tick(8);
        tests++; if (input_ports !== 2'b00) begin failed++; $display("[TB] FAIL limit_high_counting: got %b expected 00", input_ports); end
        limit = 8'd2;
        tick(1);
        tests++; if (input_ports !== 2'b01) begin failed++; $display("[TB] FAIL limit_lowered: got %b expected 01", input_ports); end
        limit = 8'd3;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        cke       = 1'b1;
        raw       = 2'b00;
        limit     = 8'd3;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        test_reset();
        test_rise_latency();
        test_fall();
        test_glitch();
        test_min_pulse();
        test_overflow();
        test_back_to_back();
        test_reset_mid_count();
        test_cke_stall();
        test_limit();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
